// File: rtl/ll_sequencer.sv
// Lunar-lander sequencer: step divider, pushbutton capture, and the
// fly/write/landed/crashed controller that drives the state-memory write enable.
module ll_sequencer #(
  parameter int unsigned TICK_DIV    = 25,
  parameter logic [15:0] THRUST_INIT = 16'h0005,
  parameter logic [15:0] SAFE_VEL    = 16'h9970,
  parameter logic [15:0] SAFE_THRUST = 16'h0005
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] pb,
  input  logic [15:0] alt,
  input  logic [15:0] vel,
  input  logic [15:0] fuel,
  input  logic [15:0] alt_n,
  output logic [15:0] thrust_n,
  output logic        wen,
  output logic        tick,
  output logic [1:0]  disp_sel,
  output logic        land,
  output logic        crash
);

  typedef enum logic [1:0] {S_FLY = 2'd0, S_WRITE = 2'd1, S_LANDED = 2'd2, S_CRASHED = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic [13:0] sync1_q, sync2_q, prev_q;
  logic [13:0] rise_s;
  logic [15:0] treq_q;
  logic [1:0]  disp_q;
  logic        td_q, us_q;
  logic        td_s, us_s;
  logic        unused_bits_s;

  // Lowest pressed digit wins when several rise together.
  function automatic logic [3:0] lowest_digit(input logic [9:0] d);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (d[i]) res = i[3:0];
    end
    return res;
  endfunction

  assign unused_bits_s = ^{alt, pb[20], pb[15:10]};

  // Step divider, free-running in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else if (cnt_q == 16'(TICK_DIV - 1)) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign tick = (cnt_q == 16'(TICK_DIV - 1));

  // Two-flop synchronizer plus previous-value flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 14'd0;
      sync2_q <= 14'd0;
      prev_q  <= 14'd0;
    end else begin
      sync1_q <= {pb[19:16], pb[9:0]};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_s = sync2_q & ~prev_q;

  // Thrust request and display select captured from button events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      treq_q <= THRUST_INIT;
      disp_q <= 2'd0;
    end else begin
      if ((state_q == S_FLY || state_q == S_WRITE) && (|rise_s[9:0])) begin
        treq_q <= {12'd0, lowest_digit(rise_s[9:0])};
      end else begin
        treq_q <= treq_q;
      end
      if (rise_s[13])      disp_q <= 2'd0;
      else if (rise_s[12]) disp_q <= 2'd1;
      else if (rise_s[11]) disp_q <= 2'd2;
      else if (rise_s[10]) disp_q <= 2'd3;
      else                 disp_q <= disp_q;
    end
  end

  assign thrust_n = (fuel == 16'h0000) ? 16'h0000 : treq_q;
  assign disp_sel = disp_q;

  assign td_s = (alt_n == 16'h0000) || (alt_n[15:12] >= 4'd5);
  assign us_s = ((vel[15:12] >= 4'd5) && (vel <= SAFE_VEL)) || (thrust_n > SAFE_THRUST);

  // State register plus touchdown/unsafe flags latched on the step strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FLY;
      td_q    <= 1'b0;
      us_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FLY && tick) begin
        td_q <= td_s;
        us_q <= us_s;
      end else begin
        td_q <= td_q;
        us_q <= us_q;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FLY:     state_d = tick ? S_WRITE : S_FLY;
      S_WRITE: begin
        if (!td_q)     state_d = S_FLY;
        else if (us_q) state_d = S_CRASHED;
        else           state_d = S_LANDED;
      end
      S_LANDED:  state_d = S_LANDED;
      S_CRASHED: state_d = S_CRASHED;
      default:   state_d = S_FLY;
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    wen   = 1'b0;
    land  = 1'b0;
    crash = 1'b0;
    case (state_q)
      S_WRITE:   wen   = 1'b1;
      S_LANDED:  land  = 1'b1;
      S_CRASHED: crash = 1'b1;
      default: begin
        wen   = 1'b0;
        land  = 1'b0;
        crash = 1'b0;
      end
    endcase
  end

endmodule
